// File: rtl/score_bcd.sv
`default_nettype none
// ============================================================================
// Module   : score_bcd
// Purpose  : Sequential 16-bit binary to 5-digit BCD converter (double-dabble)
//            for on-screen score rendering, with leading-zero blank mask.
// Revision : 1.0 - initial release
// ============================================================================
module score_bcd (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [3:0]  d0,
  output logic [3:0]  d1,
  output logic [3:0]  d2,
  output logic [3:0]  d3,
  output logic [3:0]  d4,
  output logic [4:0]  blank
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [4:0] C_NUM_SHIFTS = 5'd16;
  localparam logic [4:0] C_BLANK_RST  = 5'b11110;

  state_t      state_q, state_d;
  // Scratch layout: [35:16] five BCD nibbles, [15:0] binary shift register.
  logic [35:0] scr_q,   scr_d;
  logic [4:0]  cnt_q,   cnt_d;
  logic [19:0] dig_q,   dig_d;
  logic [4:0]  blank_q, blank_d;

  logic [35:0] w_adj;
  logic [19:0] w_new;
  logic [4:0]  w_blank;

  // Binary half passes through untouched; only the BCD nibbles are adjusted.
  assign w_adj[15:0] = scr_q[15:0];

  generate
    for (genvar i = 0; i < 5; i++) begin : g_adj
      logic [3:0] w_nib;
      assign w_nib = scr_q[16 + 4*i +: 4];
      assign w_adj[16 + 4*i +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
    end
  endgenerate

  // Leading-zero mask of the finished digits; the units digit is always shown.
  assign w_new      = scr_q[35:16];
  assign w_blank[4] = (w_new[19:16] == 4'd0);
  assign w_blank[3] = w_blank[4] & (w_new[15:12] == 4'd0);
  assign w_blank[2] = w_blank[3] & (w_new[11:8]  == 4'd0);
  assign w_blank[1] = w_blank[2] & (w_new[7:4]   == 4'd0);
  assign w_blank[0] = 1'b0;

  // State and datapath registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      scr_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      blank_q <= C_BLANK_RST;
    end else begin
      state_q <= state_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      blank_q <= blank_d;
    end
  end

  // Next-state logic: accept in IDLE, 16 adjust-and-shift steps, then publish.
  always_comb begin
    state_d = state_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    blank_d = blank_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          scr_d   = {20'd0, bin};
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q == C_NUM_SHIFTS) begin
          // Digits and mask are published together so no partial value shows.
          dig_d   = w_new;
          blank_d = w_blank;
          state_d = S_DONE;
        end else begin
          scr_d = {w_adj[34:0], 1'b0};
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy  = (state_q == S_SHIFT);
  assign done  = (state_q == S_DONE);
  assign d0    = dig_q[3:0];
  assign d1    = dig_q[7:4];
  assign d2    = dig_q[11:8];
  assign d3    = dig_q[15:12];
  assign d4    = dig_q[19:16];
  assign blank = blank_q;

endmodule
`default_nettype wire
